// File: rtl/msi_bus_pkg.sv
// Shared MSI bus definitions: op codes, controller FSM states and default sizing.
// Used by the cache controllers and by the bus controller.
package msi_bus_pkg;

    localparam int NCACHE_DEF  = 4;
    localparam int MEM_LAT_DEF = 2;
    localparam int MEM_WORDS   = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_RD    = 3'b001,
        OP_UPGR  = 3'b010,
        OP_FLUSH = 3'b011,
        OP_RDX   = 3'b100
    } bus_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_SNOOP = 3'd2,
        S_MEM   = 3'd3,
        S_DONE  = 3'd4
    } bus_state_e;

    // Reserved encodings collapse to None so the controller never acts on them.
    function automatic bus_op_e decode_op(input logic [2:0] raw);
        case (raw)
            3'b001:  return OP_RD;
            3'b010:  return OP_UPGR;
            3'b011:  return OP_FLUSH;
            3'b100:  return OP_RDX;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner, search starting at ptr.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    winner
);

    function automatic int slot(input logic [IDXW-1:0] p, input int off);
        return (int'(p) + off) % N;
    endfunction

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        winner = '0;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[slot(ptr, i)]) begin
                winner               = '0;
                winner[slot(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msi_bus_ctrl.sv
// Snooping MSI bus controller: round-robin grant, op broadcast, cache-to-cache
// flush forwarding and a fixed-latency 32 x 16-bit backing memory.
module msi_bus_ctrl
    import msi_bus_pkg::*;
#(
    parameter int NCACHE  = NCACHE_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCACHE-1:0]     req,
    output logic [NCACHE-1:0]     grant,
    input  logic [3*NCACHE-1:0]   c_op,
    input  logic [5*NCACHE-1:0]   c_addr,
    input  logic [16*NCACHE-1:0]  c_data,
    input  logic [NCACHE-1:0]     c_done,
    output logic [2:0]            bus_op,
    output logic [4:0]            bus_addr,
    output logic [15:0]           bus_data,
    output logic                  bus_done
);

    localparam int              IDXW     = (NCACHE > 1) ? $clog2(NCACHE) : 1;
    localparam logic [3:0]      LAT_INIT = 4'(MEM_LAT - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCACHE - 1);

    bus_state_e        state, state_n;
    logic [NCACHE-1:0] grant_n, arb_winner;
    logic [IDXW-1:0]   win, win_n, ptr, ptr_n, arb_idx, next_ptr;
    bus_op_e           op_n, win_op;
    logic [4:0]        addr_n, win_addr;
    logic [15:0]       data_n, win_data, snoop_data;
    logic              done_n, win_req, win_done, snoop_hit;
    logic [3:0]        cnt, cnt_n;

    logic              mem_we;
    logic [4:0]        mem_wa;
    logic [15:0]       mem_wd;
    logic [15:0]       mem [MEM_WORDS];

    rr_arbiter #(.N(NCACHE), .IDXW(IDXW)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .winner (arb_winner)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NCACHE; i++) begin
            if (arb_winner[i]) arb_idx = IDXW'(i);
        end
    end

    assign win_op   = decode_op(c_op[3*win +: 3]);
    assign win_addr = c_addr[5*win +: 5];
    assign win_data = c_data[16*win +: 16];
    assign win_req  = req[win];
    assign win_done = c_done[win];
    assign next_ptr = (win == LAST_IDX) ? '0 : win + 1'b1;

    // Flush from another cache at the latched address; lowest index is written last and wins.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        for (int k = NCACHE - 1; k >= 0; k--) begin
            if (k != int'(win) && c_done[k] && c_op[3*k +: 3] == OP_FLUSH
                && c_addr[5*k +: 5] == bus_addr) begin
                snoop_hit  = 1'b1;
                snoop_data = c_data[16*k +: 16];
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        win_n   = win;
        ptr_n   = ptr;
        op_n    = decode_op(bus_op);
        addr_n  = bus_addr;
        data_n  = bus_data;
        done_n  = 1'b0;
        cnt_n   = cnt;
        mem_we  = 1'b0;
        mem_wa  = bus_addr;
        mem_wd  = bus_data;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant_n = arb_winner;
                    win_n   = arb_idx;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                // A flush without its data yet is treated like no op: keep waiting.
                if (win_op == OP_NONE || (win_op == OP_FLUSH && !win_done)) begin
                    if (!win_req) begin
                        grant_n = '0;
                        state_n = S_IDLE;
                    end
                end else begin
                    op_n   = win_op;
                    addr_n = win_addr;
                    if (win_op == OP_FLUSH) begin
                        data_n  = win_data;
                        mem_we  = 1'b1;
                        mem_wa  = win_addr;
                        mem_wd  = win_data;
                        done_n  = 1'b1;
                        ptr_n   = next_ptr;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_SNOOP;
                    end
                end
            end
            S_SNOOP: begin
                if (bus_op == OP_UPGR) begin
                    done_n  = 1'b1;
                    ptr_n   = next_ptr;
                    state_n = S_DONE;
                end else if (snoop_hit) begin
                    data_n  = snoop_data;
                    mem_we  = 1'b1;
                    mem_wd  = snoop_data;
                    done_n  = 1'b1;
                    ptr_n   = next_ptr;
                    state_n = S_DONE;
                end else begin
                    cnt_n   = LAT_INIT;
                    state_n = S_MEM;
                end
            end
            S_MEM: begin
                if (cnt == 4'd0) begin
                    data_n  = mem[bus_addr];
                    done_n  = 1'b1;
                    ptr_n   = next_ptr;
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_DONE: begin
                grant_n = '0;
                op_n    = OP_NONE;
                addr_n  = '0;
                state_n = S_IDLE;
            end
            default: begin
                grant_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            grant    <= '0;
            win      <= '0;
            ptr      <= '0;
            bus_op   <= OP_NONE;
            bus_addr <= '0;
            bus_data <= '0;
            bus_done <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            win      <= win_n;
            ptr      <= ptr_n;
            bus_op   <= op_n;
            bus_addr <= addr_n;
            bus_data <= data_n;
            bus_done <= done_n;
            cnt      <= cnt_n;
        end
    end

    // NOTE: the memory must read back zero after reset, so it is built from resettable flops, not a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_msi_bus_ctrl.sv
// Randomized transaction-level bench for msi_bus_ctrl against a behavioural bus/memory model.
module tb_msi_bus_ctrl;

    localparam int NC = 4;
    localparam int ML = 2;

    localparam logic [2:0] C_NONE  = 3'b000;
    localparam logic [2:0] C_RD    = 3'b001;
    localparam logic [2:0] C_UPGR  = 3'b010;
    localparam logic [2:0] C_FLUSH = 3'b011;
    localparam logic [2:0] C_RDX   = 3'b100;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NC-1:0]   req;
    logic [NC-1:0]   grant;
    logic [3*NC-1:0] c_op;
    logic [5*NC-1:0] c_addr;
    logic [16*NC-1:0] c_data;
    logic [NC-1:0]   c_done;
    logic [2:0]      bus_op;
    logic [4:0]      bus_addr;
    logic [15:0]     bus_data;
    logic            bus_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_ptr = 0;
    logic [15:0] model_mem [32];

    always #5 clk = ~clk;

    msi_bus_ctrl #(.NCACHE(NC), .MEM_LAT(ML)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .c_op     (c_op),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_done   (c_done),
        .bus_op   (bus_op),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_done (bus_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req    = '0;
        c_op   = '0;
        c_addr = '0;
        c_data = '0;
        c_done = '0;
    endtask

    task automatic model_reset();
        model_ptr = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
    endtask

    // Round-robin rule: first requester found walking upward from the pointer.
    function automatic int rr_pick(input logic [NC-1:0] m);
        for (int i = 0; i < NC; i++) begin
            if (m[(model_ptr + i) % NC]) return (model_ptr + i) % NC;
        end
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},    32'(grant),    32'h0);
        check({tag, "_bus_op"},   32'(bus_op),   32'h0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'h0);
        check({tag, "_bus_data"}, 32'(bus_data), 32'h0);
        check({tag, "_bus_done"}, 32'(bus_done), 32'h0);
    endtask

    task automatic run_txn(input logic [NC-1:0] mask, input logic [2:0] op, input logic [4:0] addr,
                           input logic [15:0] wdata, input int waits, input bit abort,
                           input logic [NC-1:0] fl_en, input logic [NC-1:0] fl_match);
        int          w;
        int          lat;
        int          hit;
        logic [15:0] exp_data;
        logic [15:0] fd [NC];
        logic [31:0] exp_grant;

        w         = rr_pick(mask);
        exp_grant = 32'(1) << w;
        exp_data  = 16'h0000;
        check("idle_grant", 32'(grant), 32'h0);
        clear_inputs();
        req = mask;
        tick();
        check("grant_winner", 32'(grant), exp_grant);

        for (int i = 0; i < waits; i++) begin
            c_op[3*w +: 3] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 7)) : C_NONE;
            tick();
            check("grant_wait", 32'(grant), exp_grant);
            check("wait_bus_op", 32'(bus_op), 32'h0);
        end

        if (abort) begin
            c_op[3*w +: 3] = C_NONE;
            req[w] = 1'b0;
            tick();
            check("abort_grant", 32'(grant), 32'h0);
            check("abort_bus_op", 32'(bus_op), 32'h0);
            check("abort_done", 32'(bus_done), 32'h0);
            clear_inputs();
            return;
        end

        hit = -1;
        for (int k = 0; k < NC; k++) begin
            fd[k] = 16'($urandom);
            if (k != w && fl_en[k]) begin
                c_op[3*k +: 3]   = C_FLUSH;
                c_done[k]        = 1'b1;
                c_data[16*k +: 16] = fd[k];
                c_addr[5*k +: 5] = fl_match[k] ? addr : addr ^ 5'($urandom_range(1, 31));
                if (fl_match[k] && hit < 0) hit = k;
            end
        end
        c_op[3*w +: 3]     = op;
        c_addr[5*w +: 5]   = addr;
        c_data[16*w +: 16] = wdata;
        c_done[w]          = (op == C_FLUSH);
        if ($urandom_range(0, 1) == 1) req[w] = 1'b0;

        if (op == C_FLUSH) begin
            lat = 0;
            model_mem[addr] = wdata;
        end else if (op == C_UPGR) begin
            lat = 1;
        end else if (hit >= 0) begin
            lat = 1;
            exp_data = fd[hit];
            model_mem[addr] = fd[hit];
        end else begin
            lat = ML + 1;
            exp_data = model_mem[addr];
        end
        model_ptr = (w + 1) % NC;

        for (int c = 0; c <= lat; c++) begin
            tick();
            check("bus_op", 32'(bus_op), 32'(op));
            check("bus_addr", 32'(bus_addr), 32'(addr));
            check("grant_held", 32'(grant), exp_grant);
            check("bus_done", 32'(bus_done), 32'(c == lat));
            if (c == lat && (op == C_RD || op == C_RDX))
                check("bus_data", 32'(bus_data), 32'(exp_data));
        end

        tick();
        check("end_done", 32'(bus_done), 32'h0);
        check("end_grant", 32'(grant), 32'h0);
        check("end_bus_op", 32'(bus_op), 32'h0);
        check("end_bus_addr", 32'(bus_addr), 32'h0);
        if (op == C_RD || op == C_RDX)
            check("data_hold", 32'(bus_data), 32'(exp_data));
        clear_inputs();
    endtask

    task automatic reset_during_mem(input logic [4:0] addr);
        check("mr_idle_grant", 32'(grant), 32'h0);
        clear_inputs();
        req = 4'b0001;
        tick();
        check("mr_grant", 32'(grant), 32'h1);
        c_op[2:0]   = C_RD;
        c_addr[4:0] = addr;
        tick();
        tick();
        check("mr_bus_op", 32'(bus_op), 32'(C_RD));
        #2;
        reset = 1'b0;
        #1;
        check_outputs_zero("mr_async");
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_done", 32'(bus_done), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] op;
        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Cold read from memory, then a full round-robin sweep with every cache requesting.
        run_txn(4'b0001, C_RD, 5'h0A, 16'h0, 0, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++)
            run_txn(4'b1111, C_RD, 5'($urandom_range(0, 31)), 16'h0, 0, 1'b0, 4'b0000, 4'b0000);

        // Cache-to-cache forwarding, then memory must hold the forwarded block.
        run_txn(4'b0010, C_RDX, 5'h03, 16'h0, 0, 1'b0, 4'b0100, 4'b0100);
        run_txn(4'b0001, C_RD, 5'h03, 16'h0, 0, 1'b0, 4'b0000, 4'b0000);

        run_txn(4'b1000, C_FLUSH, 5'h1F, 16'h1234, 0, 1'b0, 4'b0000, 4'b0000);
        run_txn(4'b1000, C_RD, 5'h1F, 16'h0, 0, 1'b0, 4'b0000, 4'b0000);
        run_txn(4'b0001, C_UPGR, 5'h07, 16'h0, 1, 1'b0, 4'b0000, 4'b0000);
        run_txn(4'b0001, C_RD, 5'h07, 16'h0, 0, 1'b0, 4'b0000, 4'b0000);
        run_txn(4'b0110, C_RD, 5'h10, 16'h0, 2, 1'b1, 4'b0000, 4'b0000);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       op = C_RD;
                1:       op = C_RDX;
                2:       op = C_UPGR;
                default: op = C_FLUSH;
            endcase
            run_txn(4'($urandom_range(1, 15)), op, 5'($urandom_range(0, 31)), 16'($urandom),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
                    4'($urandom), 4'($urandom));
        end

        reset_during_mem(5'h0A);
        run_txn(4'b1111, C_RD, 5'h00, 16'h0, 0, 1'b0, 4'b0000, 4'b0000);
        for (int a = 1; a < 32; a++)
            run_txn(4'($urandom_range(1, 15)), C_RD, 5'(a), 16'h0, 0, 1'b0, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
